// File: rtl/hydra_soc_pkg.sv
// hydra_soc_pkg: address map, bus decode helper, FSM state types and UART
// frame constants shared by the hydra_soc glue logic.
package hydra_soc_pkg;

  // Address map of the native memory bus
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK  = 32'h3FFF_FFFF;
  localparam logic [31:0] LED_ADDR  = 32'h4000_0000;
  localparam logic [31:0] UART_ADDR = 32'h4000_0004;

  // start bit + 8 data bits + stop bit
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_LED  = 2'd2,
    SEL_UART = 2'd3
  } bus_sel_e;

  typedef enum logic {
    UART_IDLE = 1'b0,
    UART_SEND = 1'b1
  } uart_state_e;

  // Map a bus address onto the slave it selects; unmapped space selects none.
  function automatic bus_sel_e decode_addr(input logic [31:0] addr);
    bus_sel_e sel;
    if ((addr & ~RAM_MASK) == RAM_BASE) begin
      sel = SEL_RAM;
    end else if (addr == LED_ADDR) begin
      sel = SEL_LED;
    end else if (addr == UART_ADDR) begin
      sel = SEL_UART;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/soc_uart_tx.sv
// soc_uart_tx: 8N1 transmitter. A byte offered on send_i while idle is
// accepted, echoed on sendReq/sendData, and shifted out LSB first with one
// start and one stop bit, each BIT_CLKS clocks long. busy_o covers the whole
// frame; the next byte can be accepted the cycle after it drops.
module soc_uart_tx
  import hydra_soc_pkg::*;
#(
  parameter int unsigned BIT_CLKS = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       send_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       sendReq,
  output logic [7:0] sendData
);

  localparam int unsigned    CW          = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0]  BAUD_RELOAD = CW'(BIT_CLKS - 1);
  localparam logic [3:0]     LAST_BIT    = 4'(UART_FRAME_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bits_q, bits_d;
  logic [8:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          req_q, req_d;
  logic [7:0]    data_q, data_d;
  logic          tick_s;

  assign tick_s = (baud_q == '0);

  // Next-state logic: load the frame on accept, then step one bit per baud tick.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    req_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (send_i) begin
          state_d = UART_SEND;
          tx_d    = 1'b0;
          shift_d = {1'b1, data_i};
          bits_d  = LAST_BIT;
          baud_d  = BAUD_RELOAD;
          req_d   = 1'b1;
          data_d  = data_i;
        end else begin
          state_d = UART_IDLE;
        end
      end
      UART_SEND: begin
        if (!tick_s) begin
          baud_d = baud_q - 1'b1;
        end else if (bits_q != 4'd0) begin
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
          bits_d  = bits_q - 4'd1;
          baud_d  = BAUD_RELOAD;
        end else begin
          // stop bit has run its full period
          state_d = UART_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any frame and returns the line to idle-high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bits_q  <= 4'd0;
      shift_q <= 9'h1FF;
      tx_q    <= 1'b1;
      req_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign tx_o     = tx_q;
  assign busy_o   = (state_q == UART_SEND);
  assign sendReq  = req_q;
  assign sendData = data_q;

endmodule

// File: rtl/hydra_soc.sv
// hydra_soc: glue around the RV32 core (primary_cpu): reset stretcher,
// word RAM, LED register and UART transmitter on the core's native memory
// bus. The core attaches to the mem_* ports and is released by resetn_o.
// Optional UART is built when the macro UART_EN is defined; otherwise
// uart_tx idles high and UART writes are absorbed in one cycle.
module hydra_soc
  import hydra_soc_pkg::*;
#(
  parameter int unsigned CLK_MHZ   = 12,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned MEM_WORDS = 16384,
  parameter string       FIRMWARE  = "build/firmware.mem"
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        resetn_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic [3:0]  leds,
  output logic        uart_tx
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam int unsigned BIT_CLKS = (CLK_MHZ == 0) ? 1 : (CLK_MHZ * 1000000) / BAUD;

  logic [3:0]    rst_cnt_q, rst_cnt_d;
  logic          resetn_q;
  logic          periph_rstn_s;
  logic [31:0]   memory [MEM_WORDS];
  bus_sel_e      sel_s;
  logic [AW-1:0] ram_idx_s;
  logic          uart_wr_s, uart_busy_s, accept_s, ram_we_s;
  logic [31:0]   rdata_s;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    leds_q, leds_d;

  assign rst_cnt_d = (rst_cnt_q == 4'hF) ? rst_cnt_q : rst_cnt_q + 4'd1;

  // Reset stretcher: hold resetn low until 15 clean clocks after rstn release.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rst_cnt_q <= 4'h0;
      resetn_q  <= 1'b0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      resetn_q  <= (rst_cnt_d == 4'hF);
    end
  end

  // rstn also acts directly so a mid-frame reset silences the line at once.
  assign periph_rstn_s = resetn_q & rstn;
  assign resetn_o      = resetn_q;

  assign sel_s     = decode_addr(mem_addr_i);
  assign ram_idx_s = mem_addr_i[AW+1:2];
  assign uart_wr_s = (sel_s == SEL_UART) && mem_wstrb_i[0];
  // ready_q blocks re-accepting the request the core is still holding.
  assign accept_s  = mem_valid_i && !ready_q && !(uart_wr_s && uart_busy_s);
  assign ram_we_s  = accept_s && (sel_s == SEL_RAM);

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb_i[b]) memory[ram_idx_s][8*b +: 8] <= mem_wdata_i[8*b +: 8];
      end
    end
  end

  // Read mux for the selected slave; unmapped space reads zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (sel_s)
      SEL_RAM:  rdata_s = memory[ram_idx_s];
      SEL_LED:  rdata_s = {28'h000_0000, leds_q};
      SEL_UART: rdata_s = {31'h0000_0000, uart_busy_s};
      default:  rdata_s = 32'h0000_0000;
    endcase
  end

  // Bus response and LED next-state.
  always_comb begin
    ready_d = accept_s;
    if (accept_s) begin
      rdata_d = rdata_s;
    end else begin
      rdata_d = rdata_q;
    end
    if (accept_s && (sel_s == SEL_LED) && mem_wstrb_i[0]) begin
      leds_d = mem_wdata_i[3:0];
    end else begin
      leds_d = leds_q;
    end
  end

  // Bus response and LED registers.
  always_ff @(posedge clk) begin
    if (!periph_rstn_s) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
      leds_q  <= 4'h0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      leds_q  <= leds_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign leds        = leds_q;

`ifdef UART_EN
  logic uart_send_s;
  assign uart_send_s = accept_s && uart_wr_s;

  soc_uart_tx #(
    .BIT_CLKS (BIT_CLKS)
  ) uart0 (
    .clk      (clk),
    .rstn     (periph_rstn_s),
    .send_i   (uart_send_s),
    .data_i   (mem_wdata_i[7:0]),
    .tx_o     (uart_tx),
    .busy_o   (uart_busy_s),
    .sendReq  (),
    .sendData ()
  );
`else
  assign uart_tx     = 1'b1;
  assign uart_busy_s = 1'b0;
`endif

endmodule

// File: tb/tb_hydra_soc.sv
// tb_hydra_soc: directed bench acting as the core on the native memory bus.
// Table-driven RAM/LED/decode vectors plus hand sequences for reset, UART
// framing, UART back-pressure and mid-frame reset (UART parts follow UART_EN).
`timescale 1ns/1ps
module tb_hydra_soc;

  localparam logic [31:0] LED_A  = 32'h4000_0000;
  localparam logic [31:0] UART_A = 32'h4000_0004;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        resetn;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [3:0]  leds;
  logic        uart_tx;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_leds;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  hydra_soc #(
    .CLK_MHZ   (0),
    .BAUD      (115200),
    .MEM_WORDS (256),
    .FIRMWARE  ("")
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .resetn_o    (resetn),
    .mem_valid_i (mem_valid),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_wstrb_i (mem_wstrb),
    .mem_ready_o (mem_ready),
    .mem_rdata_o (mem_rdata),
    .leds        (leds),
    .uart_tx     (uart_tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus transaction, started and finished on a negedge.
  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output int lat);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 200);
    rd = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  // Expected line level for bit i of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  // Count clocks from rstn release to resetn; leds/uart_tx must stay idle.
  task automatic release_reset(input string tag);
    int cyc;
    logic hold_ok;
    cyc = 0;
    hold_ok = 1'b1;
    rstn = 1'b1;
    while (!resetn && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (leds !== 4'h0 || uart_tx !== 1'b1) hold_ok = 1'b0;
    end
    check({tag, "_resetn_delay"}, cyc, 15);
    check({tag, "_idle_hold"}, hold_ok, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd2;
    int lat, lat2;
    logic [3:0] exp_leds;
    logic samples [24];
    logic bits41 [10];

    vecs.push_back(vec_t'{32'h0000_0100, 32'h0000_0000, 4'hF, 1'b0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{32'h0000_0100, 32'hDEAD_BEEF, 4'h5, 1'b0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'h00AD_00EF, 4'h0});
    vecs.push_back(vec_t'{32'h0000_0104, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{32'h0000_0104, 32'hAABB_CCDD, 4'hA, 1'b0, 32'h0, 4'h0});
    vecs.push_back(vec_t'{32'h0000_0104, 32'h0, 4'h0, 1'b1, 32'hAA34_CC78, 4'h0});
    vecs.push_back(vec_t'{LED_A, 32'h0000_0003, 4'hF, 1'b0, 32'h0, 4'h3});
    vecs.push_back(vec_t'{LED_A, 32'h0, 4'h0, 1'b1, 32'h0000_0003, 4'h3});
    vecs.push_back(vec_t'{LED_A, 32'hFFFF_FFFA, 4'hF, 1'b0, 32'h0, 4'hA});
    vecs.push_back(vec_t'{LED_A, 32'h0, 4'h0, 1'b1, 32'h0000_000A, 4'hA});
    vecs.push_back(vec_t'{32'h8000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 4'hA});
    vecs.push_back(vec_t'{32'h8000_0000, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 4'hA});
    vecs.push_back(vec_t'{32'h8000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 4'hA});
    vecs.push_back(vec_t'{32'h4000_0008, 32'h0, 4'h0, 1'b1, 32'h0, 4'hA});
    vecs.push_back(vec_t'{32'h4000_0003, 32'h0, 4'h0, 1'b1, 32'h0, 4'hA});
    vecs.push_back(vec_t'{32'h0000_0500, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 4'hA});
    vecs.push_back(vec_t'{32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'h1122_3344, 4'hA});
    vecs.push_back(vec_t'{32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 4'hA});
    vecs.push_back(vec_t'{32'h3FFF_FFFC, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 4'hA});
    vecs.push_back(vec_t'{UART_A, 32'h0, 4'h0, 1'b1, 32'h0, 4'hA});

    bits41 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_leds", leds, 4'h0);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_resetn", resetn, 1'b0);
`ifdef UART_EN
    check("rst_sendReq", dut.uart0.sendReq, 1'b0);
    check("rst_uart_busy", dut.uart0.busy_o, 1'b0);
`endif
    release_reset("por");

    // ---------------- table vectors ----------------
    exp_leds = 4'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
      check($sformatf("vec%0d_latency", i), lat, 1);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
      @(negedge clk);
      check($sformatf("vec%0d_ready_pulse", i), mem_ready, 1'b0);
      exp_leds = vecs[i].exp_leds;
    end

`ifdef UART_EN
    // ---------------- single UART byte 0x41 ----------------
    bus_xfer(UART_A, 32'h0000_0041, 4'h1, rd, lat);
    check("u41_latency", lat, 1);
    check("u41_sendReq", dut.uart0.sendReq, 1'b1);
    check("u41_sendData", dut.uart0.sendData, 8'h41);
    check("u41_bit0", uart_tx, bits41[0]);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("u41_bit%0d", i), uart_tx, bits41[i]);
      if (i == 1) check("u41_sendReq_pulse", dut.uart0.sendReq, 1'b0);
    end
    check("u41_busy_at_stop", dut.uart0.busy_o, 1'b1);
    check("u41_sendData_held", dut.uart0.sendData, 8'h41);
    @(negedge clk);
    check("u41_busy_clear", dut.uart0.busy_o, 1'b0);

    // ---------------- back-to-back 0x48, 0x69 ----------------
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          @(negedge clk);
          samples[i] = uart_tx;
        end
      end
      begin
        bus_xfer(UART_A, 32'h0000_0048, 4'h1, rd, lat);
        bus_xfer(UART_A, 32'h0000_0069, 4'h1, rd2, lat2);
        check("b2b_first_latency", lat, 1);
        check("b2b_second_latency", lat2, 11);
        check("b2b_sendReq", dut.uart0.sendReq, 1'b1);
        check("b2b_sendData", dut.uart0.sendData, 8'h69);
      end
    join
    for (int i = 0; i < 10; i++) check($sformatf("b2b_f1_bit%0d", i), samples[i], frame_bit(8'h48, i));
    check("b2b_gap", samples[10], 1'b1);
    for (int i = 0; i < 10; i++) check($sformatf("b2b_f2_bit%0d", i), samples[11+i], frame_bit(8'h69, i));
    check("b2b_tail_idle", samples[23], 1'b1);

    // ---------------- reset in the middle of a frame ----------------
    @(negedge clk);
    bus_xfer(UART_A, 32'h0000_0000, 4'h1, rd, lat);
    repeat (3) @(negedge clk);
    check("mid_line_low", uart_tx, 1'b0);
    check("mid_busy", dut.uart0.busy_o, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_uart_tx", uart_tx, 1'b1);
    check("abort_busy", dut.uart0.busy_o, 1'b0);
    check("abort_sendReq", dut.uart0.sendReq, 1'b0);
`else
    // ---------------- UART absent: writes absorbed, line idle ----------------
    bus_xfer(UART_A, 32'h0000_0041, 4'h1, rd, lat);
    check("nouart_latency", lat, 1);
    begin
      logic line_ok;
      line_ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (uart_tx !== 1'b1) line_ok = 1'b0;
        @(negedge clk);
      end
      check("nouart_line_idle", line_ok, 1'b1);
    end
    bus_xfer(UART_A, 32'h0, 4'h0, rd, lat);
    check("nouart_busy_read", rd, 32'h0);
    check("nouart_busy_latency", lat, 1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_uart_tx", uart_tx, 1'b1);
`endif

    check("abort_leds", leds, 4'h0);
    check("abort_mem_ready", mem_ready, 1'b0);
    check("abort_resetn", resetn, 1'b0);
    @(negedge clk);
    release_reset("rerun");
    bus_xfer(LED_A, 32'h0, 4'h0, rd, lat);
    check("post_reset_led_read", rd, 32'h0);
    check("post_reset_ram_kept", exp_leds, 4'hA);
    bus_xfer(32'h0000_0104, 32'h0, 4'h0, rd, lat);
    check("post_reset_ram_read", rd, 32'hAA34_CC78);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hydra_soc.md
# hydra_soc

Single-core RISC-V system-on-chip wrapper: reset stretcher, firmware-initialised word RAM, memory-mapped LED register and UART transmitter around one RV32 core (`primary_cpu`, existing picorv32-style core with native memory interface). Top level of the FPGA/simulation build; firmware reports status on `leds` and text on `uart_tx`. The RTL in scope is the glue: reset, RAM, bus decode, peripherals.

## Interface
- `CLK_MHZ`, 12: clock frequency in MHz; 0 = simulation mode (one clock per UART bit).
- `BAUD`, 115200: UART bit rate when `CLK_MHZ` > 0.
- `MEM_WORDS`, 16384: RAM depth in 32-bit words (power of two).
- `FIRMWARE`, "build/firmware.mem": `$readmemh` image loaded into RAM at time 0.
- Reset `rstn`, synchronous, active-low; clock `clk`.
- `clk`  input  1  system clock.
- `rstn`  input  1  synchronous active-low reset.
- `leds`  output  4  LED register; by firmware convention bit0 = run finished, bit1 = crypto phase active.
- `uart_tx`  output  1  8N1 serial output, idle high.

## Operation
- Internal `resetn`: 4-bit counter cleared while `rstn`=0, increments to 15 and saturates; `resetn`=1 when counter = 15. Core and peripherals reset by `resetn`.
- RAM array named `memory`, `[31:0]` x `MEM_WORDS`; index = `mem_addr[..:2]` mod `MEM_WORDS`. Writes honour `mem_wstrb` per byte. Contents not cleared by reset.
- Map: `0x0000_0000-0x3FFF_FFFF` RAM; `0x4000_0000` LED (write bits[3:0], read returns them); `0x4000_0004` UART data (write byte[7:0]; read bit0 = busy); everything else reads 0, writes ignored.
- UART sub-block `uart0` exposes `sendReq` (1-cycle pulse when byte accepted) and `sendData` (accepted byte, held until next accept). Frame: start 0, 8 data bits LSB first, stop 1; bit period = `CLK_MHZ*1e6/BAUD` clocks, or 1 clock when `CLK_MHZ`=0.
- UART write while busy: `mem_ready` withheld until idle; no byte dropped.

## Timing
- Every transaction: `mem_ready` pulses one cycle, the cycle after `mem_valid` seen (UART stall excepted); read data valid with `mem_ready`.
- Reset values: `leds`=0, `uart_tx`=1, `sendReq`=0, `mem_ready`=0, UART idle.
- `resetn` rises 15 cycles after first clock edge with `rstn`=1; `rstn` low mid-frame aborts frame, `uart_tx` returns 1 next cycle.
- UART busy from accept until stop bit end (10 bit periods); next accept possible the following cycle.

## Configuration
- `UART_EN`: defined → `uart0` instantiated as above. Undefined → no UART; `uart_tx` tied 1, UART writes complete in one cycle and are discarded, busy reads 0.

## Structure
- Package `hydra_soc_pkg`: address map constants (`RAM_BASE`, `LED_ADDR`, `UART_ADDR`), UART frame length.
- One sub-module: `soc_uart_tx` (baud divider, shift register, busy, `sendReq`/`sendData`).

## Test plan
- `rstn` low 3 cycles then high → `resetn` high exactly 15 cycles later; `leds`=0, `uart_tx`=1 throughout.
- Write `0xDEADBEEF` to `0x100` with wstrb `0b0101`, read back → `0x00AD00EF` over prior zero word.
- Write `0x3` to `0x4000_0000` → `leds`=`4'b0011` cycle after `mem_ready`; read returns 3.
- `CLK_MHZ`=0, write `0x41` to UART → `sendReq` 1-cycle pulse, `sendData`=0x41, `uart_tx` sequence 0,1,0,0,0,0,0,1,0,1 one bit per clock.
- Two back-to-back UART writes `0x48`,`0x69` → second `mem_ready` delayed until first frame ends; both frames intact.
- Read `0x8000_0000` → 0 with single-cycle `mem_ready`; `rstn` low mid-frame → `uart_tx`=1, busy cleared.
